cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles allowed waiting for burst_resp before abort (used only under REQ-030).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pmem_address  input  32  line address from cache.
REQ-005 pmem_read  input  1  line read request, held until pmem_resp.
REQ-006 pmem_write  input  1  line write request, held until pmem_resp.
REQ-007 pmem_wdata  input  256  line to write.
REQ-008 pmem_rdata  output  256  line read back.
REQ-009 pmem_resp  output  1  one-cycle completion pulse to cache.
REQ-010 burst_address  output  32  memory address, bits [4:0] forced 0.
REQ-011 burst_read  output  1  burst read request.
REQ-012 burst_write  output  1  burst write request.
REQ-013 burst_wdata  output  64  current write beat.
REQ-014 burst_rdata  input  64  current read beat.
REQ-015 burst_resp  input  1  memory beat handshake; one beat transferred per cycle high.
REQ-016 error  output  1  timeout abort flag (REQ-030).

Function
REQ-017 FSM states IDLE, READ, WRITE, DONE; 2-bit beat counter 0..3.
REQ-018 IDLE: pmem_write high -> latch address and pmem_wdata, counter=0, go WRITE; else pmem_read high -> latch address, counter=0, go READ; write wins when both high.
REQ-019 Requests sampled only in IDLE; request changes in other states ignored.
REQ-020 burst_read high exactly while in READ; burst_write high exactly while in WRITE; burst_address = latched address with [4:0]=0, held constant through the burst.
REQ-021 READ: each cycle burst_resp=1 -> store burst_rdata into pmem_rdata[64*k+63:64*k], k=counter, counter++; after beat 3 go DONE.
REQ-022 WRITE: burst_wdata = latched line[64*k+63:64*k], k=counter; each cycle burst_resp=1 -> counter++; after beat 3 go DONE.
REQ-023 burst_resp low mid-burst stalls: counter and captured data hold, request stays asserted; beats need not be consecutive.
REQ-024 Beat order ascending: beat 0 = line bits [63:0].
REQ-025 DONE: pmem_resp=1 for exactly one cycle, then IDLE; burst_read/burst_write low in DONE.
REQ-026 Latency with zero-wait memory: request in IDLE at cycle 0, beats cycles 1-4, pmem_resp cycle 5; back-to-back request accepted earliest in the cycle after pmem_resp.
REQ-027 pmem_rdata registered; holds last completed read line until next read overwrites beats; unchanged by writes.
REQ-028 burst_resp in IDLE or DONE ignored.

Reset
REQ-029 rst=1 at a clock edge -> state IDLE, counter 0, pmem_resp/burst_read/burst_write/error 0, pmem_rdata/burst_wdata 0, latched address 0; in-flight burst abandoned without pmem_resp.

Configuration
REQ-030 Macro CACHELINE_ADAPTOR_TIMEOUT_EN defined: watchdog counts consecutive cycles in READ/WRITE with burst_resp=0, cleared on any beat or state entry; reaching TIMEOUT -> go DONE, pmem_resp pulse with error=1 same cycle, partial read data left as captured.
REQ-031 Macro undefined: no watchdog logic; error tied 0; READ/WRITE wait indefinitely.

Verification
REQ-032 Read, zero-wait: pmem_read, addr 0x0000_1234, beats 0x11..11,0x22..22,0x33..33,0x44..44 -> burst_address 0x0000_1220, pmem_rdata = {0x44..,0x33..,0x22..,0x11..}, pmem_resp on cycle 5 only.
REQ-033 Write with stalls: pmem_write, line {D3,D2,D1,D0}, burst_resp pattern 1,0,0,1,1,0,1 -> burst_wdata D0,D1,D1,D1,D2,D3,D3 per cycle; pmem_resp cycle after last accepted beat.
REQ-034 Simultaneous pmem_read and pmem_write in IDLE -> burst_write asserted, burst_read never asserted, read data unchanged.
REQ-035 rst asserted after beat 2 of read -> next cycle IDLE, all burst/pmem_resp outputs 0, no pmem_resp; subsequent read completes normally.
REQ-036 With CACHELINE_ADAPTOR_TIMEOUT_EN, TIMEOUT=8, burst_resp held 0 after read -> pmem_resp and error high together 9 cycles after request accepted; without macro, burst_read stays high, no pmem_resp.

Source files
------------

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module   : cacheline_adaptor
//  Purpose  : Bridges 256-bit cache-line requests to a 4-beat x 64-bit burst
//             memory.  A write or read request is latched in IDLE, moved
//             over the burst port in ascending beat order (beat 0 = line
//             bits [63:0]) and acknowledged with a one-cycle pmem_resp.
//             Requests arriving while a transfer is in progress are ignored.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             pmem_*            - cache side (address, read/write, line data,
//                                 completion pulse)
//             burst_*           - memory side (aligned address, read/write
//                                 request, 64-bit beat data, beat handshake)
//             error             - set together with pmem_resp on watchdog abort
//  Options  : CACHELINE_ADAPTOR_TIMEOUT_EN - when defined, a watchdog aborts a
//             burst after TIMEOUT consecutive cycles without a beat.  When
//             undefined, bursts wait forever and error is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module cacheline_adaptor #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pmem_address,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    output logic [31:0]  burst_address,
    output logic         burst_read,
    output logic         burst_write,
    output logic [63:0]  burst_wdata,
    input  logic [63:0]  burst_rdata,
    input  logic         burst_resp,
    output logic         error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Clears the byte-within-line offset; the memory works on whole lines.
    localparam logic [31:0] C_LINE_MASK = 32'hFFFF_FFE0;

    state_e         state_q,       state_d;
    logic [1:0]     cnt_q,         cnt_d;
    logic [31:0]    addr_q,        addr_d;
    logic [255:0]   line_q,        line_d;
    logic [255:0]   rdata_q,       rdata_d;
    logic           pmem_resp_q,   pmem_resp_d;
    logic           burst_read_q,  burst_read_d;
    logic           burst_write_q, burst_write_d;
    logic [63:0]    wdata_q,       wdata_d;
    logic           timeout_hit;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT-1; the abort fires on the cycle
    // that would make it TIMEOUT.
    localparam int             C_WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT - 1);

    logic [C_WD_W-1:0] wd_q, wd_d;
    logic              error_q, error_d;

    always_comb begin
        wd_d        = '0;
        timeout_hit = 1'b0;
        // Any beat, and any cycle outside READ/WRITE, restarts the count, so
        // entering a burst always begins from zero.
        if ((state_q == READ || state_q == WRITE) && !burst_resp) begin
            if (wd_q == C_WD_LAST) begin
                timeout_hit = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    assign error_d = timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                // Write has priority when both requests are present.
                if (pmem_write) begin
                    addr_d  = pmem_address & C_LINE_MASK;
                    line_d  = pmem_wdata;
                    cnt_d   = 2'd0;
                    state_d = WRITE;
                end else if (pmem_read) begin
                    addr_d  = pmem_address & C_LINE_MASK;
                    cnt_d   = 2'd0;
                    state_d = READ;
                end
            end
            READ: begin
                if (burst_resp) begin
                    rdata_d[{cnt_q, 6'd0} +: 64] = burst_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = DONE;
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                if (burst_resp) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = DONE;
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next-state view so they line up
        // exactly with the state they describe.
        pmem_resp_d   = (state_d == DONE);
        burst_read_d  = (state_d == READ);
        burst_write_d = (state_d == WRITE);
        wdata_d       = line_d[{cnt_d, 6'd0} +: 64];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            addr_q        <= 32'd0;
            line_q        <= 256'd0;
            rdata_q       <= 256'd0;
            pmem_resp_q   <= 1'b0;
            burst_read_q  <= 1'b0;
            burst_write_q <= 1'b0;
            wdata_q       <= 64'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            line_q        <= line_d;
            rdata_q       <= rdata_d;
            pmem_resp_q   <= pmem_resp_d;
            burst_read_q  <= burst_read_d;
            burst_write_q <= burst_write_d;
            wdata_q       <= wdata_d;
        end
    end

    assign pmem_rdata    = rdata_q;
    assign pmem_resp     = pmem_resp_q;
    assign burst_address = addr_q;
    assign burst_read    = burst_read_q;
    assign burst_write   = burst_write_q;
    assign burst_wdata   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cacheline_adaptor
//  Purpose  : Directed self-checking bench for cacheline_adaptor: a per-cycle
//             vector table for back-to-back read and stalled write, plus
//             hand sequences for simultaneous requests, reset mid-burst and
//             the watchdog (both with and without CACHELINE_ADAPTOR_TIMEOUT_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [255:0] RLINE = {B4, B3, B2, B1};

    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D2 = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] D3 = 64'h1357_9BDF_2468_ACE0;
    localparam logic [255:0] WLINE = {D3, D2, D1, D0};

    localparam logic [63:0] E0 = 64'hE000_0000_0000_00E0;
    localparam logic [63:0] E1 = 64'hE111_1111_1111_11E1;
    localparam logic [63:0] E2 = 64'hE222_2222_2222_22E2;
    localparam logic [63:0] E3 = 64'hE333_3333_3333_33E3;

    localparam logic [63:0] S0 = 64'h5000_0000_0000_0005;
    localparam logic [63:0] S1 = 64'h5111_0000_0000_1115;
    localparam logic [63:0] S2 = 64'h5222_0000_0000_2225;
    localparam logic [63:0] S3 = 64'h5333_0000_0000_3335;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;
    logic         error;

    int checks   = 0;
    int failures = 0;

    cacheline_adaptor #(.TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_address  (pmem_address),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp),
        .error         (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic         bresp;
        logic [63:0]  brdata;
        logic         exp_resp;
        logic         exp_bread;
        logic         exp_bwrite;
        logic         chk_addr;
        logic [31:0]  exp_addr;
        logic         chk_wdata;
        logic [63:0]  exp_wdata;
        logic         chk_rdata;
        logic [255:0] exp_rdata;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where registered outputs
    // are settled and inputs for the new cycle can be driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst          = 1'b1;
        pmem_address = 32'd0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = WLINE;
        burst_rdata  = 64'd0;
        burst_resp   = 1'b0;

        // Read 0x1234 zero-wait, then back-to-back stalled write.
        // Address changes during bursts must not reach burst_address.
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_1234, 1'b0, 64'd0,                  1'b0, 1'b0, 1'b0, 1'b0, 32'd0,            1'b0, 64'd0, 1'b1, 256'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, B1,                     1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1220,    1'b0, 64'd0, 1'b0, 256'd0};
        vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, B2,                     1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1220,    1'b0, 64'd0, 1'b0, 256'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, B3,                     1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1220,    1'b0, 64'd0, 1'b0, 256'd0};
        vecs[4]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, B4,                     1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1220,    1'b0, 64'd0, 1'b0, 256'd0};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,           1'b0, 64'd0, 1'b1, RLINE};
        vecs[6]  = '{1'b0, 1'b1, 32'hABCD_EF1F, 1'b1, 64'hBEEF_BEEF_BEEF_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,           1'b0, 64'd0, 1'b1, RLINE};
        vecs[7]  = '{1'b0, 1'b1, 32'd0,         1'b1, 64'd0,                  1'b0, 1'b0, 1'b1, 1'b1, 32'hABCD_EF00,    1'b1, D0,    1'b0, 256'd0};
        vecs[8]  = '{1'b0, 1'b1, 32'd0,         1'b0, 64'd0,                  1'b0, 1'b0, 1'b1, 1'b1, 32'hABCD_EF00,    1'b1, D1,    1'b0, 256'd0};
        vecs[9]  = '{1'b0, 1'b1, 32'd0,         1'b0, 64'd0,                  1'b0, 1'b0, 1'b1, 1'b1, 32'hABCD_EF00,    1'b1, D1,    1'b0, 256'd0};
        vecs[10] = '{1'b0, 1'b1, 32'd0,         1'b1, 64'd0,                  1'b0, 1'b0, 1'b1, 1'b1, 32'hABCD_EF00,    1'b1, D1,    1'b0, 256'd0};
        vecs[11] = '{1'b0, 1'b1, 32'd0,         1'b1, 64'd0,                  1'b0, 1'b0, 1'b1, 1'b1, 32'hABCD_EF00,    1'b1, D2,    1'b0, 256'd0};
        vecs[12] = '{1'b0, 1'b1, 32'd0,         1'b0, 64'd0,                  1'b0, 1'b0, 1'b1, 1'b1, 32'hABCD_EF00,    1'b1, D3,    1'b0, 256'd0};
        vecs[13] = '{1'b0, 1'b1, 32'd0,         1'b1, 64'd0,                  1'b0, 1'b0, 1'b1, 1'b1, 32'hABCD_EF00,    1'b1, D3,    1'b0, 256'd0};
        vecs[14] = '{1'b0, 1'b1, 32'd0,         1'b0, 64'd0,                  1'b1, 1'b0, 1'b0, 1'b0, 32'd0,            1'b0, 64'd0, 1'b1, RLINE};
        vecs[15] = '{1'b0, 1'b0, 32'd0,         1'b0, 64'd0,                  1'b0, 1'b0, 1'b0, 1'b0, 32'd0,            1'b0, 64'd0, 1'b1, RLINE};

        // ---------------- reset state ----------------
        tick();
        tick();
        check("reset pmem_resp",     pmem_resp,     1'b0);
        check("reset burst_read",    burst_read,    1'b0);
        check("reset burst_write",   burst_write,   1'b0);
        check("reset error",         error,         1'b0);
        check("reset pmem_rdata",    pmem_rdata,    256'd0);
        check("reset burst_wdata",   burst_wdata,   64'd0);
        check("reset burst_address", burst_address, 32'd0);
        rst = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 16; i++) begin
            pmem_read    = vecs[i].rd;
            pmem_write   = vecs[i].wr;
            pmem_address = vecs[i].addr;
            burst_resp   = vecs[i].bresp;
            burst_rdata  = vecs[i].brdata;
            check($sformatf("row%0d pmem_resp", i),   pmem_resp,   vecs[i].exp_resp);
            check($sformatf("row%0d burst_read", i),  burst_read,  vecs[i].exp_bread);
            check($sformatf("row%0d burst_write", i), burst_write, vecs[i].exp_bwrite);
            check($sformatf("row%0d error", i),       error,       1'b0);
            if (vecs[i].chk_addr)
                check($sformatf("row%0d burst_address", i), burst_address, vecs[i].exp_addr);
            if (vecs[i].chk_wdata)
                check($sformatf("row%0d burst_wdata", i), burst_wdata, vecs[i].exp_wdata);
            if (vecs[i].chk_rdata)
                check($sformatf("row%0d pmem_rdata", i), pmem_rdata, vecs[i].exp_rdata);
            tick();
        end

        // ---------------- simultaneous read + write: write wins ----------------
        pmem_address = 32'h0000_5555;
        pmem_wdata   = {E3, E2, E1, E0};
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        burst_resp   = 1'b0;
        tick();
        check("both burst_address", burst_address, 32'h0000_5540);
        for (int b = 0; b < 4; b++) begin
            burst_resp  = 1'b1;
            burst_rdata = 64'h7777_7777_7777_7777;
            check($sformatf("both beat%0d burst_read", b),  burst_read,  1'b0);
            check($sformatf("both beat%0d burst_write", b), burst_write, 1'b1);
            case (b)
                0: check("both beat0 burst_wdata", burst_wdata, E0);
                1: check("both beat1 burst_wdata", burst_wdata, E1);
                2: check("both beat2 burst_wdata", burst_wdata, E2);
                default: check("both beat3 burst_wdata", burst_wdata, E3);
            endcase
            tick();
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        burst_resp = 1'b0;
        check("both done pmem_resp", pmem_resp,  1'b1);
        check("both done burst_read", burst_read, 1'b0);
        tick();
        check("both after pmem_resp",  pmem_resp,  1'b0);
        check("both after pmem_rdata", pmem_rdata, RLINE);

        // ---------------- reset after beat 2 of a read ----------------
        pmem_address = 32'h0000_2000;
        pmem_read    = 1'b1;
        tick();
        for (int b = 0; b < 3; b++) begin
            burst_resp  = 1'b1;
            burst_rdata = 64'hC0C0_0000_0000_0000 | 64'(b);
            check($sformatf("rstmid beat%0d burst_read", b), burst_read, 1'b1);
            tick();
        end
        rst        = 1'b1;
        pmem_read  = 1'b0;
        burst_resp = 1'b0;
        tick();
        rst = 1'b0;
        check("rstmid burst_read",    burst_read,    1'b0);
        check("rstmid burst_write",   burst_write,   1'b0);
        check("rstmid pmem_resp",     pmem_resp,     1'b0);
        check("rstmid pmem_rdata",    pmem_rdata,    256'd0);
        check("rstmid burst_address", burst_address, 32'd0);
        check("rstmid burst_wdata",   burst_wdata,   64'd0);
        tick();
        check("rstmid later pmem_resp",  pmem_resp,  1'b0);
        check("rstmid later burst_read", burst_read, 1'b0);

        // Follow-up read after reset completes normally.
        pmem_address = 32'h0000_3FFF;
        pmem_read    = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            burst_resp = 1'b1;
            case (b)
                0: burst_rdata = S0;
                1: burst_rdata = S1;
                2: burst_rdata = S2;
                default: burst_rdata = S3;
            endcase
            check($sformatf("reread beat%0d burst_read", b), burst_read, 1'b1);
            check($sformatf("reread beat%0d pmem_resp", b),  pmem_resp,  1'b0);
            tick();
        end
        pmem_read  = 1'b0;
        burst_resp = 1'b0;
        check("reread burst_address", burst_address, 32'h0000_3FE0);
        check("reread pmem_resp",     pmem_resp,     1'b1);
        tick();
        check("reread pmem_rdata",      pmem_rdata, {S3, S2, S1, S0});
        check("reread after pmem_resp", pmem_resp,  1'b0);

        // ---------------- watchdog ----------------
        pmem_address = 32'h0000_0100;
        pmem_read    = 1'b1;
        burst_resp   = 1'b0;
        tick();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("wd cyc%0d burst_read", c), burst_read, 1'b1);
            check($sformatf("wd cyc%0d pmem_resp", c),  pmem_resp,  1'b0);
            check($sformatf("wd cyc%0d error", c),      error,      1'b0);
            tick();
        end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        pmem_read = 1'b0;
        check("wd abort pmem_resp",  pmem_resp,  1'b1);
        check("wd abort error",      error,      1'b1);
        check("wd abort burst_read", burst_read, 1'b0);
        tick();
        check("wd after pmem_resp", pmem_resp, 1'b0);
        check("wd after error",     error,     1'b0);
`else
        for (int c = 9; c <= 24; c++) begin
            check($sformatf("wd cyc%0d burst_read", c), burst_read, 1'b1);
            check($sformatf("wd cyc%0d pmem_resp", c),  pmem_resp,  1'b0);
            check($sformatf("wd cyc%0d error", c),      error,      1'b0);
            tick();
        end
        pmem_read = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("wd cleanup burst_read", burst_read, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
